// File: rtl/dpr_row_mac_if.sv
// Bundles the control, DPR read, x-buffer read and result signals of one row MAC.
// The master side is the MAC; the slave side is the array controller and memories.
interface dpr_row_mac_if #(
  parameter int FEATURE_BITS = 4,
  parameter int ELEMENT_BITS = 8,
  parameter int ACC_BITS     = 2*ELEMENT_BITS+FEATURE_BITS
);
  logic                      start;
  logic [FEATURE_BITS:0]     n_rows;
  logic [FEATURE_BITS:0]     n_cols;
  logic [2*FEATURE_BITS-1:0] address_out;
  logic                      oe_out;
  logic                      cs_out;
  logic [ELEMENT_BITS-1:0]   data_in;
  logic [FEATURE_BITS-1:0]   x_addr;
  logic                      x_re;
  logic [ELEMENT_BITS-1:0]   x_data;
  logic [ACC_BITS-1:0]       y_data;
  logic [FEATURE_BITS-1:0]   y_row;
  logic                      y_valid;
  logic                      busy;
  logic                      done;

  modport master (
    input  start, n_rows, n_cols, data_in, x_data,
    output address_out, oe_out, cs_out, x_addr, x_re,
           y_data, y_row, y_valid, busy, done
  );

  modport slave (
    output start, n_rows, n_cols, data_in, x_data,
    input  address_out, oe_out, cs_out, x_addr, x_re,
           y_data, y_row, y_valid, busy, done
  );
endinterface

// File: rtl/dpr_row_mac.sv
// Streams one weight matrix out of a DPR with matching x elements and emits y = W*x row by row.
// One address per cycle, y_valid two cycles after a row's last address; no backpressure.
module dpr_row_mac #(
  parameter int FEATURE_BITS = 4,
  parameter int ELEMENT_BITS = 8,
  parameter int ACC_BITS     = 2*ELEMENT_BITS+FEATURE_BITS
) (
  input logic           sys_clk,
  input logic           reset_n,
  dpr_row_mac_if.master bus
);
  localparam int PROD_BITS = 2*ELEMENT_BITS;
  localparam int EXT_BITS  = ACC_BITS-PROD_BITS;
  localparam logic [FEATURE_BITS-1:0]   ONE_F = {{(FEATURE_BITS-1){1'b0}}, 1'b1};
  localparam logic [FEATURE_BITS:0]     ONE_D = {{FEATURE_BITS{1'b0}}, 1'b1};
  localparam logic [2*FEATURE_BITS-1:0] ONE_L = {{(2*FEATURE_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

  state_t                    state_q, state_d;
  logic [FEATURE_BITS:0]     rows_q, rows_d, cols_q, cols_d;
  logic [FEATURE_BITS-1:0]   row_q, row_d, col_q, col_d;
  logic [2*FEATURE_BITS-1:0] lin_q, lin_d;
  logic                      rd_q, rd_d;
  logic                      busy_q, busy_d, done_q, done_d;
  logic                      p_vld_q, p_vld_d, p_first_q, p_first_d, p_last_q, p_last_d;
  logic [FEATURE_BITS-1:0]   p_row_q, p_row_d;
  logic [ACC_BITS-1:0]       acc_q, acc_d, y_data_q, y_data_d;
  logic [FEATURE_BITS-1:0]   y_row_q, y_row_d;
  logic                      y_valid_q, y_valid_d;

  logic signed [PROD_BITS-1:0] w_ext, x_ext, prod_raw;
  logic [ACC_BITS-1:0]         prod_ext, acc_next;
  logic                        last_col, last_row;

  assign w_ext    = {{ELEMENT_BITS{bus.data_in[ELEMENT_BITS-1]}}, bus.data_in};
  assign x_ext    = {{ELEMENT_BITS{bus.x_data[ELEMENT_BITS-1]}}, bus.x_data};
  assign prod_raw = w_ext * x_ext;
  assign prod_ext = {{EXT_BITS{prod_raw[PROD_BITS-1]}}, prod_raw};
  // First column restarts the sum so nothing from the previous row leaks in.
  assign acc_next = p_first_q ? prod_ext : acc_q + prod_ext;

  assign last_col = ({1'b0, col_q} == cols_q - ONE_D);
  assign last_row = ({1'b0, row_q} == rows_q - ONE_D);

  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    row_d     = row_q;
    col_d     = col_q;
    lin_d     = lin_q;
    rd_d      = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    p_vld_d   = 1'b0;
    p_first_d = p_first_q;
    p_last_d  = p_last_q;
    p_row_d   = p_row_q;
    acc_d     = acc_q;
    y_data_d  = y_data_q;
    y_row_d   = y_row_q;
    y_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // A start in the done cycle still counts as arriving while busy.
        if (bus.start && !done_q) begin
          if (bus.n_rows != '0 && bus.n_cols != '0) begin
            rows_d  = bus.n_rows;
            cols_d  = bus.n_cols;
            row_d   = '0;
            col_d   = '0;
            lin_d   = '0;
            rd_d    = 1'b1;
            busy_d  = 1'b1;
            state_d = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        p_vld_d   = 1'b1;
        p_first_d = (col_q == '0);
        p_last_d  = last_col;
        p_row_d   = row_q;
        if (last_col && last_row) begin
          state_d = DRAIN;
        end else begin
          rd_d  = 1'b1;
          lin_d = lin_q + ONE_L;
          if (last_col) begin
            col_d = '0;
            row_d = row_q + ONE_F;
          end else begin
            col_d = col_q + ONE_F;
          end
        end
      end
      DRAIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (p_vld_q) begin
      acc_d = acc_next;
      if (p_last_q) begin
        y_data_d  = acc_next;
        y_row_d   = p_row_q;
        y_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rows_q    <= '0;
      cols_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      lin_q     <= '0;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      p_vld_q   <= 1'b0;
      p_first_q <= 1'b0;
      p_last_q  <= 1'b0;
      p_row_q   <= '0;
      acc_q     <= '0;
      y_data_q  <= '0;
      y_row_q   <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      row_q     <= row_d;
      col_q     <= col_d;
      lin_q     <= lin_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      p_vld_q   <= p_vld_d;
      p_first_q <= p_first_d;
      p_last_q  <= p_last_d;
      p_row_q   <= p_row_d;
      acc_q     <= acc_d;
      y_data_q  <= y_data_d;
      y_row_q   <= y_row_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign bus.address_out = lin_q;
  assign bus.oe_out      = rd_q;
  assign bus.cs_out      = rd_q;
  assign bus.x_re        = rd_q;
  assign bus.x_addr      = col_q;
  assign bus.y_data      = y_data_q;
  assign bus.y_row       = y_row_q;
  assign bus.y_valid     = y_valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_dpr_row_mac.sv
// Directed bench for dpr_row_mac with a registered-read DPR and x buffer model.
module tb_dpr_row_mac;
  localparam int FB = 4;
  localparam int EB = 8;
  localparam int AB = 2*EB+FB;

  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  dpr_row_mac_if #(.FEATURE_BITS(FB), .ELEMENT_BITS(EB), .ACC_BITS(AB)) bus ();

  dpr_row_mac #(.FEATURE_BITS(FB), .ELEMENT_BITS(EB), .ACC_BITS(AB)) dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [EB-1:0] w_mem [256];
  logic [EB-1:0] x_mem [16];

  always @(posedge sys_clk) begin
    if (bus.cs_out && bus.oe_out) bus.data_in <= w_mem[bus.address_out];
    if (bus.x_re) bus.x_data <= x_mem[bus.x_addr];
  end

  typedef struct {
    int           rows;
    int           cols;
    logic [127:0] w;
    logic [127:0] x;
    int           y[4];
    int           spur;
  } vec_t;

  vec_t vecs[7];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int i);
    for (int j = 0; j < 16; j++) begin
      w_mem[j] = vecs[i].w[j*8 +: 8];
      x_mem[j] = vecs[i].x[j*8 +: 8];
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int done_k, n_addr, bad_addr, bad_strobe, busy1, busy_done, exp_lat, exp_y;
    int ys[$];
    int yr[$];
    v = vecs[i];
    load(i);
    done_k = 0; n_addr = 0; bad_addr = 0; bad_strobe = 0; busy1 = 0; busy_done = 1;
    @(negedge sys_clk);
    bus.n_rows = (FB+1)'(v.rows);
    bus.n_cols = (FB+1)'(v.cols);
    bus.start  = 1'b1;
    for (int k = 1; k <= 300 && done_k == 0; k++) begin
      @(negedge sys_clk);
      if (bus.oe_out) begin
        if (int'(bus.address_out) != n_addr) bad_addr++;
        if (int'(bus.x_addr) != n_addr % v.cols) bad_addr++;
        n_addr++;
      end
      if (bus.cs_out !== bus.oe_out || bus.x_re !== bus.oe_out) bad_strobe++;
      if (k == 1) busy1 = int'(bus.busy);
      if (bus.y_valid) begin
        yr.push_back(int'(bus.y_row));
        ys.push_back(int'($signed(bus.y_data)));
      end
      if (bus.done) begin
        done_k    = k;
        busy_done = int'(bus.busy);
      end
      bus.start = (v.spur != 0 && k == 2);
      if (v.spur != 0 && k == 2) begin
        bus.n_rows = 5'd1;
        bus.n_cols = 5'd1;
      end
    end
    bus.start = 1'b0;
    exp_lat = (v.rows * v.cols == 0) ? 1 : v.rows * v.cols + 2;
    exp_y   = (v.rows * v.cols == 0) ? 0 : v.rows;
    check($sformatf("v%0d_done_latency", i), done_k, exp_lat);
    check($sformatf("v%0d_busy_after_start", i), busy1, (v.rows * v.cols != 0) ? 1 : 0);
    check($sformatf("v%0d_busy_at_done", i), busy_done, 0);
    check($sformatf("v%0d_addr_count", i), n_addr, v.rows * v.cols);
    check($sformatf("v%0d_addr_sequence_errs", i), bad_addr, 0);
    check($sformatf("v%0d_strobe_errs", i), bad_strobe, 0);
    check($sformatf("v%0d_y_count", i), ys.size(), exp_y);
    for (int r = 0; r < ys.size() && r < 4; r++) begin
      check($sformatf("v%0d_y_row%0d", i, r), yr[r], r);
      check($sformatf("v%0d_y_data%0d", i, r), ys[r], v.y[r]);
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.n_rows = '0;
    bus.n_cols = '0;

    vecs[0].rows = 2; vecs[0].cols = 3; vecs[0].spur = 0;
    vecs[0].w = 128'h060504030201; vecs[0].x = 128'h020101;
    vecs[0].y = '{9, 21, 0, 0};
    vecs[1].rows = 1; vecs[1].cols = 16; vecs[1].spur = 0;
    vecs[1].w = {16{8'h80}}; vecs[1].x = {16{8'h80}};
    vecs[1].y = '{262144, 0, 0, 0};
    vecs[2].rows = 1; vecs[2].cols = 4; vecs[2].spur = 0;
    vecs[2].w = 128'hFF01807F; vecs[2].x = 128'h808001FF;
    vecs[2].y = '{-255, 0, 0, 0};
    vecs[3].rows = 4; vecs[3].cols = 1; vecs[3].spur = 0;
    vecs[3].w = 128'h0705FE03; vecs[3].x = 128'h02;
    vecs[3].y = '{6, -4, 10, 14};
    vecs[4].rows = 3; vecs[4].cols = 3; vecs[4].spur = 0;
    vecs[4].w = 128'h090807060504030201; vecs[4].x = 128'h02FF01;
    vecs[4].y = '{5, 11, 17, 0};
    vecs[5].rows = 0; vecs[5].cols = 5; vecs[5].spur = 0;
    vecs[5].w = '0; vecs[5].x = '0;
    vecs[5].y = '{0, 0, 0, 0};
    vecs[6] = vecs[0];
    vecs[6].spur = 1;

    repeat (3) @(negedge sys_clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_y_valid", bus.y_valid, 0);
    check("reset_oe_cs_xre", {bus.oe_out, bus.cs_out, bus.x_re}, 0);
    check("reset_address", bus.address_out, 0);
    check("reset_y_data", bus.y_data, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i);

    // start landing in the done cycle must be dropped
    run_vec(0);
    bus.n_rows = 5'd2;
    bus.n_cols = 5'd2;
    bus.start  = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    check("start_at_done_busy", bus.busy, 0);
    check("start_at_done_oe", bus.oe_out, 0);
    @(negedge sys_clk);
    check("start_at_done_oe_later", bus.oe_out, 0);
    check("start_at_done_no_done", bus.done, 0);

    // asynchronous reset in the middle of a 3x3 pass
    load(4);
    @(negedge sys_clk);
    bus.n_rows = 5'd3;
    bus.n_cols = 5'd3;
    bus.start  = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    repeat (5) @(negedge sys_clk);
    check("pre_reset_y_data", int'($signed(bus.y_data)), 5);
    check("pre_reset_oe", bus.oe_out, 1);
    reset_n = 1'b0;
    #1;
    check("midreset_oe_cs_xre", {bus.oe_out, bus.cs_out, bus.x_re}, 0);
    check("midreset_address", bus.address_out, 0);
    check("midreset_x_addr", bus.x_addr, 0);
    check("midreset_y_data", bus.y_data, 0);
    check("midreset_y_row", bus.y_row, 0);
    check("midreset_flags", {bus.y_valid, bus.busy, bus.done}, 0);
    repeat (3) @(negedge sys_clk);
    check("held_reset_flags", {bus.y_valid, bus.busy, bus.done, bus.oe_out}, 0);
    reset_n = 1'b1;
    @(negedge sys_clk);
    check("post_reset_idle", {bus.y_valid, bus.busy, bus.done, bus.oe_out}, 0);
    run_vec(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dpr_row_mac.md
Name: dpr_row_mac

Overview:
- Downstream consumer of one weight DPR in the systolic array.
- Sequences read addresses into the DPR and reads a matching input-vector element from the x buffer.
- Multiplies each weight by its x element and accumulates across a row, computing y = W·x for one weight matrix.
- Emits one signed dot product per matrix row, then pulses done; one instance per DPR (P in top).

Parameters:
- FEATURE_BITS, 4, bits to count features; row/col index width.
- ELEMENT_BITS, 8, signed width of weight and x elements.
- ACC_BITS, 2*ELEMENT_BITS+FEATURE_BITS, signed accumulator / y_data width.

Ports:
- sys_clk  in  1  systolic array clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse, begins a matrix-vector pass; ignored while busy
- n_rows  in  FEATURE_BITS+1  row count, sampled on accepted start
- n_cols  in  FEATURE_BITS+1  column count, sampled on accepted start
- address_out  out  2*FEATURE_BITS  DPR read address, row*n_cols+col
- oe_out  out  1  DPR output enable
- cs_out  out  1  DPR chip select
- data_in  in  ELEMENT_BITS  DPR data_out (signed), valid 1 cycle after address issue
- x_addr  out  FEATURE_BITS  x buffer address (= col)
- x_re  out  1  x buffer read enable
- x_data  in  ELEMENT_BITS  x element (signed), valid 1 cycle after x_addr/x_re
- y_data  out  ACC_BITS  row dot product (signed)
- y_row  out  FEATURE_BITS  row index of y_data
- y_valid  out  1  one-cycle pulse, y_data/y_row valid
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse, pass complete

Behaviour:
- All outputs registered. On reset (asynchronous, any time, including mid-pass): every output = 0, FSM to IDLE, counters and accumulator cleared; no partial y_valid or done is emitted after reset.
- FSM states: IDLE, READ, DRAIN.
  - IDLE: on start with n_rows>0 and n_cols>0, latch dims, clear row/col/address counters, go to READ; busy=1 from the next cycle.
  - Zero dims: start with n_rows=0 or n_cols=0 gives done=1 the next cycle, busy stays 0, no reads, no y_valid.
- READ:
  - Each cycle drives oe_out=cs_out=x_re=1, address_out = linear counter, x_addr = col.
  - col increments each cycle; at col=n_cols-1, col wraps to 0 and row increments.
  - The linear address increments by 1 every cycle.
  - After issuing row=n_rows-1, col=n_cols-1, go to DRAIN.
- DRAIN: oe_out=cs_out=x_re=0. Stay 1 cycle, then go to IDLE.
- Strobes: oe_out, cs_out and x_re are 0 outside READ.
- Data pipeline: the first/last/row tags of an issued address are delayed 1 cycle to align with data_in/x_data.
  - prod = signed data_in × signed x_data, sign-extended to ACC_BITS.
  - First column: acc <= prod. Otherwise: acc <= acc + prod.
  - Last column: y_data <= acc + prod, y_row <= tagged row, y_valid=1 next cycle.
- Latency: last address of a row issued in cycle t gives y_valid in cycle t+2. A pass of R×C takes R·C+2 cycles from start to the final y_valid.
- done pulses in the same cycle as the final y_valid; busy drops to 0 in that cycle.
- y_data/y_row hold their value between pulses. y_valid=0 otherwise.
- Arithmetic: two's complement with no saturation; overflow wraps at ACC_BITS. The default ACC_BITS cannot overflow for n_cols ≤ 2^FEATURE_BITS.
- n_cols=1: every cycle is both first and last; y_valid every cycle after the pipeline fills.
- Legal dims: 0..2^FEATURE_BITS each, and n_rows·n_cols ≤ 2^(2·FEATURE_BITS). Larger values are illegal input; no checking is required.
- start asserted while busy: ignored, latched dims unchanged. start in the cycle done pulses: ignored (busy treated as still set until the following cycle).

Test Plan:
- Basic 2×3: W=[[1,2,3],[4,5,6]], x=[1,1,2], start → addresses 0..5 in consecutive cycles; y_valid twice: y_row=0 y=9, y_row=1 y=21; done with the second y_valid, 8 cycles after start.
- Signed extremes: 1×16 with all W=-128, all x=-128 → y_data=262144, no wrap. 1×4 with W=[127,-128,1,-1], x=[-1,1,-128,-128] → y=-255+0=-255 (−127−128−128+128).
- n_cols=1, n_rows=4: W=[3,-2,5,7], x0=2 → y_valid 4 consecutive cycles: 6, -4, 10, 14.
- Zero dims: start with n_rows=0, n_cols=5 → done 1 cycle later, oe_out/cs_out never 1, no y_valid.
- start while busy: second start mid-pass with different dims → ignored; original address sequence and results unchanged.
- Reset mid-pass: reset_n low during READ of a 3×3 pass → all outputs 0 immediately. New start after release → correct full results, no stale accumulator contribution.
